// File: rtl/level_loader_pkg.sv
// Shared types and sizing for the level loader, the tile-map RAM and the renderer.
// The tile count and index width are fixed for the 32x32 map.
package level_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        WRITE,
        FINISH
    } state_t;

    localparam int TILE_W          = 8;
    localparam int INDEX_W         = 10;
    localparam int LEVEL_W         = 3;
    localparam int ROM_ADDR_W      = 30;
    localparam int TILES_PER_LEVEL = 1024;

    // Word address of a tile: base + level*tiles + index.
    function automatic logic [ROM_ADDR_W-1:0] tile_rom_addr(
        input int                 base,
        input int                 tiles,
        input logic [LEVEL_W-1:0] lvl,
        input logic [INDEX_W-1:0] idx
    );
        return ROM_ADDR_W'(base) + ROM_ADDR_W'(lvl) * ROM_ADDR_W'(tiles) + ROM_ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/level_loader.sv
// Copies one tile level from the levels ROM into the tile-map RAM, one tile per 3 cycles.
// Optional feature: define LEVEL_LOADER_CHECKSUM_EN to add the mod-256 checksum port.
module level_loader
    import level_loader_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROWS     = 32,
    parameter int LEVELS   = 8,
    parameter int ROM_BASE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEVEL_W-1:0]    level,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rom_cs,
    output logic                  rom_read,
    output logic [ROM_ADDR_W-1:0] rom_address,
    input  logic [TILE_W-1:0]     rom_data,
    output logic                  map_write,
    output logic [INDEX_W-1:0]    map_address,
    output logic [TILE_W-1:0]     map_data,
    input  logic                  map_ready
`ifdef LEVEL_LOADER_CHECKSUM_EN
    ,
    output logic [TILE_W-1:0]     checksum
`endif
);

    localparam int                 TILES    = COLS * ROWS;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(TILES - 1);

    state_t                  r_state;
    logic [LEVEL_W-1:0]      r_level;
    logic [INDEX_W-1:0]      r_index;
    logic [TILE_W-1:0]       r_hold;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_rom_cs;
    logic [ROM_ADDR_W-1:0]   r_rom_addr;
    logic                    r_map_write;

    logic                    w_level_ok;
    logic                    w_start_accept;
    logic                    w_write_accept;

    assign w_level_ok     = int'(level) < LEVELS;
    assign w_start_accept = (r_state == IDLE) && start;
    assign w_write_accept = (r_state == WRITE) && map_ready;

    // ROM strobes and address are only ever loaded on the edge entering FETCH,
    // so they are settled well before the ROM's negedge sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_level     <= '0;
            r_index     <= '0;
            r_hold      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_rom_cs    <= 1'b0;
            r_rom_addr  <= '0;
            r_map_write <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_level <= level;
                        r_index <= '0;
                        if (w_level_ok) begin
                            r_error    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_rom_cs   <= 1'b1;
                            r_rom_addr <= tile_rom_addr(ROM_BASE, TILES, level, '0);
                            r_state    <= FETCH;
                        end else begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    r_rom_cs <= 1'b0;
                    r_state  <= CAPTURE;
                end
                CAPTURE: begin
                    r_hold      <= rom_data;
                    r_map_write <= 1'b1;
                    r_state     <= WRITE;
                end
                WRITE: begin
                    if (map_ready) begin
                        r_map_write <= 1'b0;
                        if (r_index == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_index    <= r_index + 1'b1;
                            r_rom_cs   <= 1'b1;
                            r_rom_addr <= tile_rom_addr(ROM_BASE, TILES, r_level, r_index + 1'b1);
                            r_state    <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef LEVEL_LOADER_CHECKSUM_EN
    logic [TILE_W-1:0] r_checksum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_accept) begin
            r_checksum <= '0;
        end else if (w_write_accept) begin
            r_checksum <= r_checksum + r_hold;
        end
    end

    assign checksum = r_checksum;
`else
    logic w_unused_ok;
    assign w_unused_ok = w_start_accept ^ w_write_accept;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign rom_cs      = r_rom_cs;
    assign rom_read    = r_rom_cs;
    assign rom_address = r_rom_addr;
    assign map_write   = r_map_write;
    assign map_address = r_index;
    assign map_data    = r_hold;

endmodule
